mem_access_master: RTL

//  Initiator side of the data_memory port (memWrite/memRead/address/writeData/readData).

---
 rtl/mem_access_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_master.sv
// Load/store initiator for the data_memory port: word accesses go straight through,
// sub-word stores do a read-modify-write, and loads return extracted, extended data.
module mem_access_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        memWrite,
  output logic        memRead,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, RESP} state_t;

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

  state_t        stateReg, stateNext;
  logic [CW-1:0] cntReg;
  logic [1:0]    sizeReg;
  logic          signedReg;
  logic [1:0]    laneReg;
  logic [31:0]   wdataReg;
  logic [31:0]   addressReg;
  logic [31:0]   writeDataReg;
  logic [31:0]   rdataReg;
  logic          errorReg;

  logic          misaligned;
  logic          cntDone;
  logic [7:0]    selByte;
  logic [15:0]   selHalf;
  logic [31:0]   loadData;
  logic [31:0]   mergeMask;
  logic [31:0]   mergeData;
  logic [31:0]   mergedWord;

  assign cntDone = (cntReg == '0);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction for loads; word loads pass readData through untouched.
  always_comb begin
    selByte  = readData[{laneReg, 3'b000} +: 8];
    selHalf  = readData[{laneReg[1], 4'b0000} +: 16];
    loadData = readData;
    case (sizeReg)
      2'b00:   loadData = signedReg ? {{24{selByte[7]}}, selByte} : {24'b0, selByte};
      2'b01:   loadData = signedReg ? {{16{selHalf[15]}}, selHalf} : {16'b0, selHalf};
      default: loadData = readData;
    endcase
  end

  always_comb begin
    if (sizeReg == 2'b00) begin
      mergeMask = 32'h0000_00FF << {laneReg, 3'b000};
      mergeData = {24'b0, wdataReg[7:0]} << {laneReg, 3'b000};
    end else begin
      mergeMask = 32'h0000_FFFF << {laneReg[1], 4'b0000};
      mergeData = {16'b0, wdataReg[15:0]} << {laneReg[1], 4'b0000};
    end
    mergedWord = (readData & ~mergeMask) | mergeData;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    req_ready = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    rsp_valid = 1'b0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)             stateNext = RESP;
          else if (!req_write)        stateNext = READ;
          else if (req_size == 2'b10) stateNext = WRITE;
          else                        stateNext = RMW_RD;
        end
      end
      READ: begin
        memRead = 1'b1;
        if (cntDone) stateNext = RESP;
      end
      RMW_RD: begin
        memRead = 1'b1;
        if (cntDone) stateNext = WRITE;
      end
      WRITE: begin
        memWrite  = 1'b1;
        stateNext = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // writeData only changes at acceptance (word store) or at the end of RMW_RD,
  // so it is stable for the whole WRITE cycle and holds through IDLE.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cntReg       <= '0;
      sizeReg      <= 2'b00;
      signedReg    <= 1'b0;
      laneReg      <= 2'b00;
      wdataReg     <= 32'h0;
      addressReg   <= 32'h0;
      writeDataReg <= 32'h0;
      rdataReg     <= 32'h0;
      errorReg     <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req_valid) begin
            sizeReg   <= req_size;
            signedReg <= req_signed;
            laneReg   <= req_addr[1:0];
            wdataReg  <= req_wdata;
            rdataReg  <= 32'h0;
            errorReg  <= misaligned;
            cntReg    <= CNT_INIT;
            if (!misaligned) begin
              addressReg <= {2'b00, req_addr[31:2]};
              if (req_write && req_size == 2'b10) writeDataReg <= req_wdata;
            end
          end
        end
        READ: begin
          if (cntDone) rdataReg <= loadData;
          else         cntReg   <= cntReg - 1'b1;
        end
        RMW_RD: begin
          if (cntDone) writeDataReg <= mergedWord;
          else         cntReg       <= cntReg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign address   = addressReg;
  assign writeData = writeDataReg;
  assign rsp_rdata = rdataReg;
  assign rsp_error = errorReg;

endmodule
